// File: rtl/button_events.sv
// button_events: turns the clean button level into PRESS / RELEASE / LONG /
// REPEAT events and queues them in a small show-ahead FIFO with a
// valid/ready drain port and a sticky overflow flag.
module button_events #(
    parameter int ACTIVE_LOW    = 0,
    parameter int CNT_W         = 24,
    parameter int LONG_CYCLES   = 1000000,
    parameter int REPEAT_CYCLES = 250000,
    parameter int DEPTH         = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_sig,
    input  logic       i_evt_ready,
    input  logic       i_ovf_clr,
    output logic       o_evt_valid,
    output logic [1:0] o_evt_code,
    output logic       o_level,
    output logic       o_overflow
);

    localparam int AW = $clog2(DEPTH);

    // Counter compare values are "threshold minus one" because the counter
    // is cleared on the edge that starts each interval.
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST =
        CNT_W'((REPEAT_CYCLES == 0) ? 0 : REPEAT_CYCLES - 1);
    localparam logic REPEAT_EN  = (REPEAT_CYCLES != 0);
    localparam logic INVERT_SIG = (ACTIVE_LOW != 0);

    localparam logic [1:0] EVT_PRESS   = 2'b00;
    localparam logic [1:0] EVT_RELEASE = 2'b01;
    localparam logic [1:0] EVT_LONG    = 2'b10;
    localparam logic [1:0] EVT_REPEAT  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_HELD    = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             prev_reg;
    logic             overflow_reg;
    logic [AW:0]      wr_ptr_reg, rd_ptr_reg;
    logic [1:0]       mem_reg [DEPTH];

    logic       level;
    logic       rise;
    logic       fall;
    logic       push;
    logic [1:0] push_code;
    logic       fifo_empty;
    logic       fifo_full;
    logic       pop;
    logic       do_push;
    logic       drop;

    assign level = i_sig ^ INVERT_SIG;
    assign rise  = level & ~prev_reg;
    assign fall  = ~level & prev_reg;

    // Edge detector history; also serves as the registered level output.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            prev_reg <= 1'b0;
        end else begin
            prev_reg <= level;
        end
    end

    // FSM state and hold counter registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state and event generation; a fall always beats a threshold hit.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        push       = 1'b0;
        push_code  = EVT_PRESS;
        case (state_reg)
            ST_IDLE: begin
                if (rise) begin
                    push       = 1'b1;
                    push_code  = EVT_PRESS;
                    cnt_next   = '0;
                    state_next = ST_PRESSED;
                end
            end
            ST_PRESSED: begin
                if (fall) begin
                    push       = 1'b1;
                    push_code  = EVT_RELEASE;
                    state_next = ST_IDLE;
                end else if (cnt_reg == LONG_LAST) begin
                    push       = 1'b1;
                    push_code  = EVT_LONG;
                    cnt_next   = '0;
                    state_next = ST_HELD;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            ST_HELD: begin
                if (fall) begin
                    push       = 1'b1;
                    push_code  = EVT_RELEASE;
                    state_next = ST_IDLE;
                end else if (REPEAT_EN && (cnt_reg == REPEAT_LAST)) begin
                    push      = 1'b1;
                    push_code = EVT_REPEAT;
                    cnt_next  = '0;
                end else if (REPEAT_EN) begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // FIFO status: extra pointer bit distinguishes full from empty.
    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                        (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign pop        = ~fifo_empty & i_evt_ready;
    // A pop on the same edge frees the slot, so a push into a full FIFO
    // still lands when the head is being consumed.
    assign do_push    = push & (~fifo_full | pop);
    assign drop       = push & fifo_full & ~pop;

    // FIFO pointers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    // Event storage; contents need no reset because reads are gated by empty.
    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg[AW-1:0]] <= push_code;
        end
    end

    // Sticky overflow; a drop on the same edge as a clear wins.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            overflow_reg <= 1'b0;
        end else if (drop) begin
            overflow_reg <= 1'b1;
        end else if (i_ovf_clr) begin
            overflow_reg <= 1'b0;
        end
    end

    assign o_evt_valid = ~fifo_empty;
    assign o_evt_code  = fifo_empty ? 2'b00 : mem_reg[rd_ptr_reg[AW-1:0]];
    assign o_level     = prev_reg;
    assign o_overflow  = overflow_reg;

endmodule

// File: tb/tb_button_events.sv
// Testbench for button_events: vector table for short-press and boundary
// release, plus hand-written sequences for long hold, backpressure,
// reset mid-hold and the active-low input option.
module tb_button_events;

    localparam int LONG  = 8;
    localparam int REP   = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       sig, rdy, clr;
    logic       sig2, rdy2;
    logic       valid, level, ovf;
    logic [1:0] code;
    logic       valid2, level2, ovf2;
    logic [1:0] code2;

    always #5 clk = ~clk;

    button_events #(
        .ACTIVE_LOW(0), .CNT_W(8), .LONG_CYCLES(LONG),
        .REPEAT_CYCLES(REP), .DEPTH(DEPTH)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_sig(sig), .i_evt_ready(rdy),
        .i_ovf_clr(clr), .o_evt_valid(valid), .o_evt_code(code),
        .o_level(level), .o_overflow(ovf)
    );

    button_events #(
        .ACTIVE_LOW(1), .CNT_W(8), .LONG_CYCLES(LONG),
        .REPEAT_CYCLES(REP), .DEPTH(DEPTH)
    ) dut_al (
        .i_clk(clk), .i_rst(rst), .i_sig(sig2), .i_evt_ready(rdy2),
        .i_ovf_clr(clr), .o_evt_valid(valid2), .o_evt_code(code2),
        .o_level(level2), .o_overflow(ovf2)
    );

    typedef struct {
        logic       sig;
        logic       rdy;
        logic       clr;
        logic       ev;
        logic [1:0] ec;
        logic       el;
        logic       eo;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic void add(input logic s, input logic r, input logic c,
                                input logic ev, input logic [1:0] ec,
                                input logic el, input logic eo);
        vec_t v;
        v.sig = s; v.rdy = r; v.clr = c;
        v.ev = ev; v.ec = ec; v.el = el; v.eo = eo;
        vecs.push_back(v);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic show(input string tag, input int idx);
        $display("%s %0d: sig=%b rdy=%b valid=%b code=%b level=%b ovf=%b",
                 tag, idx, sig, rdy, valid, code, level, ovf);
    endtask

    initial begin
        rst = 1'b1; sig = 1'b0; rdy = 1'b0; clr = 1'b0;
        sig2 = 1'b1; rdy2 = 1'b0;

        // Short press: 5 cycles high, then low; no LONG may appear.
        add(0,1,0, 0,2'b00,0,0);
        add(1,1,0, 1,2'b00,1,0);
        for (int i = 0; i < 4; i++) add(1,1,0, 0,2'b00,1,0);
        add(0,1,0, 1,2'b01,0,0);
        add(0,1,0, 0,2'b00,0,0);
        // Boundary release: fall sampled exactly at N+LONG.
        add(1,1,0, 1,2'b00,1,0);
        for (int i = 0; i < LONG - 1; i++) add(1,1,0, 0,2'b00,1,0);
        add(0,1,0, 1,2'b01,0,0);
        for (int i = 0; i < 3; i++) add(0,1,0, 0,2'b00,0,0);

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {3'b0, valid}, 4'd0);
        chk("rst_code", {2'b0, code}, 4'd0);
        chk("rst_level", {3'b0, level}, 4'd0);
        chk("rst_ovf", {3'b0, ovf}, 4'd0);
        chk("rst_valid_al", {3'b0, valid2}, 4'd0);
        chk("rst_level_al", {3'b0, level2}, 4'd0);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven vectors.
        for (int i = 0; i < vecs.size(); i++) begin
            sig = vecs[i].sig; rdy = vecs[i].rdy; clr = vecs[i].clr;
            step();
            show("vec", i);
            chk("vec_valid", {3'b0, valid}, {3'b0, vecs[i].ev});
            if (vecs[i].ev) chk("vec_code", {2'b0, code}, {2'b0, vecs[i].ec});
            chk("vec_level", {3'b0, level}, {3'b0, vecs[i].el});
            chk("vec_ovf", {3'b0, ovf}, {3'b0, vecs[i].eo});
        end
        clr = 1'b0;

        // Long hold: PRESS at N, LONG at N+8, REPEAT at N+12/16/20, RELEASE at N+21.
        for (int k = 0; k <= 22; k++) begin
            logic       ev;
            logic [1:0] ec;
            sig = (k <= 20); rdy = 1'b1;
            step();
            show("hold", k);
            ev = (k == 0) || (k == 8) || (k == 12) || (k == 16) || (k == 20) || (k == 21);
            ec = (k == 0) ? 2'b00 : (k == 8) ? 2'b10 : (k == 21) ? 2'b01 : 2'b11;
            chk("hold_valid", {3'b0, valid}, {3'b0, ev});
            if (ev) chk("hold_code", {2'b0, code}, {2'b0, ec});
            chk("hold_level", {3'b0, level}, {3'b0, sig});
        end

        // Backpressure: three short presses with ready low; last two events drop.
        rdy = 1'b0;
        for (int i = 0; i < 12; i++) begin
            sig = ((i % 4) < 2);
            step();
            show("bp", i);
            chk("bp_valid", {3'b0, valid}, 4'd1);
            chk("bp_head", {2'b0, code}, 4'd0);
            chk("bp_ovf", {3'b0, ovf}, {3'b0, logic'(i >= 8)});
        end
        sig = 1'b0; clr = 1'b1;
        step();
        show("ovf_clr", 0);
        chk("ovf_cleared", {3'b0, ovf}, 4'd0);
        chk("ovf_clr_valid", {3'b0, valid}, 4'd1);
        clr = 1'b0;

        // Full FIFO: press pushed on the same edge as a pop, then drain.
        sig = 1'b1; rdy = 1'b1;
        begin
            logic [1:0] exp_heads [4];
            exp_heads[0] = 2'b01; exp_heads[1] = 2'b00;
            exp_heads[2] = 2'b01; exp_heads[3] = 2'b00;
            for (int i = 0; i < 4; i++) begin
                step();
                show("drain", i);
                chk("drain_valid", {3'b0, valid}, 4'd1);
                chk("drain_code", {2'b0, code}, {2'b0, exp_heads[i]});
                chk("drain_ovf", {3'b0, ovf}, 4'd0);
            end
        end
        step();
        show("drain", 4);
        chk("drain_empty", {3'b0, valid}, 4'd0);
        sig = 1'b0;
        step();
        show("drain_rel", 0);
        chk("drain_rel_valid", {3'b0, valid}, 4'd1);
        chk("drain_rel_code", {2'b0, code}, 4'd1);
        step();
        chk("drain_rel_pop", {3'b0, valid}, 4'd0);

        // Reset while HELD with PRESS and LONG queued.
        rdy = 1'b0; sig = 1'b1;
        for (int k = 0; k <= 9; k++) begin
            step();
            show("held", k);
            chk("held_valid", {3'b0, valid}, 4'd1);
            chk("held_head", {2'b0, code}, 4'd0);
        end
        rst = 1'b1;
        #2;
        show("mid_rst", 0);
        chk("mid_rst_valid", {3'b0, valid}, 4'd0);
        chk("mid_rst_level", {3'b0, level}, 4'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        step();
        show("post_rst", 0);
        chk("post_rst_valid", {3'b0, valid}, 4'd1);
        chk("post_rst_code", {2'b0, code}, 4'd0);
        chk("post_rst_level", {3'b0, level}, 4'd1);
        chk("post_rst_ovf", {3'b0, ovf}, 4'd0);

        // Active-low input: 1 is released, 0 is pressed.
        rdy2 = 1'b1; sig2 = 1'b1;
        step();
        chk("al_idle_valid", {3'b0, valid2}, 4'd0);
        chk("al_idle_level", {3'b0, level2}, 4'd0);
        sig2 = 1'b0;
        step();
        $display("al 0: sig2=%b valid2=%b code2=%b level2=%b", sig2, valid2, code2, level2);
        chk("al_press_valid", {3'b0, valid2}, 4'd1);
        chk("al_press_code", {2'b0, code2}, 4'd0);
        chk("al_press_level", {3'b0, level2}, 4'd1);
        step();
        chk("al_pop", {3'b0, valid2}, 4'd0);
        sig2 = 1'b1;
        step();
        $display("al 1: sig2=%b valid2=%b code2=%b level2=%b", sig2, valid2, code2, level2);
        chk("al_rel_valid", {3'b0, valid2}, 4'd1);
        chk("al_rel_code", {2'b0, code2}, 4'd1);
        chk("al_rel_level", {3'b0, level2}, 4'd0);
        step();
        chk("al_rel_pop", {3'b0, valid2}, 4'd0);
        chk("al_ovf", {3'b0, ovf2}, 4'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/button_events.md
# button_events

Converts the debounced button level into a queue of discrete key events: press, release, long-press and auto-repeat. It sits directly downstream of the button debouncer and consumes its clean output level. A small event FIFO with a valid/ready handshake lets firmware-facing logic, such as a CSR or interrupt source, drain events at its own pace.

## Interface
- `ACTIVE_LOW`, 0: when 1, `i_sig` low means pressed; the logical level is `i_sig ^ ACTIVE_LOW`.
- `CNT_W`, 24: hold-counter width.
- `LONG_CYCLES`, 1000000: held cycles from PRESS to LONG. Must be ≥1 and < 2^CNT_W.
- `REPEAT_CYCLES`, 250000: cycles between REPEAT events after LONG. 0 disables repeat. Must be < 2^CNT_W.
- `DEPTH`, 4: FIFO entries, a power of 2, ≥2.
- `i_clk`  in  1  clock; the only clock domain.
- `i_rst`  in  1  asynchronous, active-high reset.
- `i_sig`  in  1  debounced button level, already synchronous to `i_clk`.
- `i_evt_ready`  in  1  consumer accepts the head event.
- `i_ovf_clr`  in  1  clears `o_overflow`.
- `o_evt_valid`  out  1  FIFO non-empty.
- `o_evt_code`  out  2  head event: 00 PRESS, 01 RELEASE, 10 LONG, 11 REPEAT.
- `o_level`  out  1  registered logical button level.
- `o_overflow`  out  1  sticky flag: at least one event was dropped.

## Operation
- `r_prev` holds the logical level registered on the previous edge. `o_level = r_prev`.
- Rise: the logical level is 1 and `r_prev` is 0.
- Fall: the logical level is 0 and `r_prev` is 1.
- FSM states are IDLE, PRESSED and HELD. Reset state is IDLE.
- IDLE:
  - On rise: push PRESS, clear the counter, go to PRESSED.
  - Otherwise: stay in IDLE.
- PRESSED:
  - On fall: push RELEASE, go to IDLE.
  - Else, when the counter equals `LONG_CYCLES-1`: push LONG, clear the counter, go to HELD.
  - Else: increment the counter.
- HELD:
  - On fall: push RELEASE, go to IDLE.
  - Else, if `REPEAT_CYCLES` ≠ 0 and the counter equals `REPEAT_CYCLES-1`: push REPEAT, clear the counter.
  - Else, if `REPEAT_CYCLES` ≠ 0: increment the counter.
  - If `REPEAT_CYCLES` = 0: the counter holds.
- Release on the same edge the counter hits a threshold: fall has priority. Only RELEASE is pushed; LONG and REPEAT are not.
- At most one event is generated per cycle.
- The counter never wraps, because the thresholds are below 2^CNT_W.
- FIFO behaviour:
  - Show-ahead: `o_evt_code` is valid whenever `o_evt_valid` is 1.
  - Pop when `o_evt_valid && i_evt_ready`.
  - Pointers are `log2(DEPTH)+1` bits wide and wrap naturally.
  - Full is the pointer MSBs differing with equal low bits.
- Full FIFO with a push and no pop: the new event is dropped and `o_overflow` is set.
  - The FSM still transitions normally.
  - `o_level` always tracks the input.
- Full FIFO with a push and a pop in the same cycle: the push succeeds and the occupancy stays at DEPTH.
- Empty FIFO with a push: no bypass. `o_evt_valid` rises the cycle after the push.
- `i_ovf_clr` clears `o_overflow`. If a clear and a new drop occur in the same cycle, set wins.
- `o_evt_code` is don't-care when `o_evt_valid` is 0.

## Timing
- Reset (async assert, sync release):
  - State IDLE, counter 0, `r_prev` = 0, FIFO empty.
  - `o_evt_valid` = 0, `o_level` = 0, `o_overflow` = 0.
  - `o_evt_code` reads 00.
- Button already pressed at reset release: a rise is seen at the first edge, so PRESS is pushed.
- PRESS timing, with the logical level first sampled 1 at edge N:
  - `o_level` = 1 after edge N.
  - PRESS is written at edge N.
  - `o_evt_valid` = 1 after edge N if the FIFO was empty.
- LONG is written at edge N+LONG_CYCLES.
- REPEAT k (k ≥ 1) is written at edge N+LONG_CYCLES+k·REPEAT_CYCLES.
- RELEASE is written at the edge where the fall is sampled.
- Pop takes effect at the edge where `valid && ready`. The next entry is presented after that edge.
- Throughput: one pop per cycle.
- Reset asserted mid-operation: the FIFO contents and any pending hold are discarded immediately. No RELEASE is emitted.

## Test plan
- Short press, with LONG_CYCLES=8 and `i_evt_ready`=1. Drive level 1 for 5 cycles, then 0. Required: PRESS, then RELEASE, and no LONG. `o_level` tracks the input one cycle late.
- Long hold, with LONG=8, REPEAT=4. Hold for 20 cycles after the press edge N. Required:
  - PRESS at N, LONG at N+8.
  - REPEAT at N+12, N+16 and N+20 if still held, then RELEASE.
- Boundary release, with LONG=8. The fall is sampled exactly at edge N+8. Required: RELEASE only, no LONG, state returns to IDLE.
- Backpressure, with DEPTH=4 and `i_evt_ready`=0. Run 3 short presses (6 events). Required:
  - The first 4 events are kept in order: PRESS, RELEASE, PRESS, RELEASE.
  - `o_overflow`=1.
  - After pulsing `i_ovf_clr`, `o_overflow`=0.
  - A full-FIFO cycle with a simultaneous push and pop keeps the occupancy at 4 and loses no events.
- Reset mid-HELD with 2 events queued. Required: `o_evt_valid`=0 and `o_level`=0 immediately. If the input is still pressed after release, a fresh PRESS arrives on the first edge.
- `ACTIVE_LOW`=1. Drive `i_sig` 1→0. Required: PRESS and `o_level`=1. Driving 0→1 gives RELEASE.
